// File: rtl/primary_ray_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module      : primary_ray_dispatch_if
//  Description : Bundles the four handshake channels around the primary ray
//                dispatcher (ray generator in, traversal out, shader retire
//                in, pixel write out) plus the status outputs.
//                  slave  : the dispatcher's view
//                  master : the surrounding environment's view
//  Ports       : none (signals only)
//  Revision    : 1.0 - initial release
// ============================================================================
interface primary_ray_dispatch_if #(
    parameter int ID_W  = 4,
    parameter int PIX_W = 19
);
    // ray generator -> dispatcher: {pixelID, origin.xyz, dir.xyz}
    logic                  prg_to_shader_valid;
    logic [PIX_W+191:0]    prg_to_shader_data;
    logic                  prg_to_shader_stall;
    // dispatcher -> traversal: {rayID, origin.xyz, dir.xyz}
    logic                  trav_valid;
    logic [ID_W+191:0]     trav_data;
    logic                  trav_stall;
    // shader -> dispatcher: retired ray and its final colour
    logic                  done_valid;
    logic [ID_W-1:0]       done_rayID;
    logic [23:0]           done_color;
    logic                  done_stall;
    // dispatcher -> frame buffer
    logic                  pix_valid;
    logic [PIX_W-1:0]      pix_pixelID;
    logic [23:0]           pix_color;
    logic                  pix_stall;
    // status
    logic [ID_W:0]         in_flight;
    logic                  err;

    modport slave (
        input  prg_to_shader_valid, prg_to_shader_data,
        output prg_to_shader_stall,
        output trav_valid, trav_data,
        input  trav_stall,
        input  done_valid, done_rayID, done_color,
        output done_stall,
        output pix_valid, pix_pixelID, pix_color,
        input  pix_stall,
        output in_flight, err
    );

    modport master (
        output prg_to_shader_valid, prg_to_shader_data,
        input  prg_to_shader_stall,
        input  trav_valid, trav_data,
        output trav_stall,
        output done_valid, done_rayID, done_color,
        input  done_stall,
        input  pix_valid, pix_pixelID, pix_color,
        output pix_stall,
        input  in_flight, err
    );
endinterface
`default_nettype wire

// File: rtl/primary_ray_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : primary_ray_dispatch
//  Description : Assigns a rayID from a free list to every primary ray taken
//                from the ray generator, remembers the ray's pixelID in a
//                slot table and forwards the ray to traversal. When the
//                shader retires a rayID, the pixelID is looked up, a pixel
//                write is emitted and the rayID is returned to the free list.
//  Ports       : clk   - clock
//                rst   - asynchronous active-high reset
//                bus   - primary_ray_dispatch_if.slave (all handshakes,
//                        in_flight count and sticky err flag)
//  Revision    : 1.0 - initial release
// ============================================================================
module primary_ray_dispatch #(
    parameter int NUM_RAYS = 16,
    parameter int ID_W     = 4,
    parameter int PIX_W    = 19
) (
    input  wire logic               clk,
    input  wire logic               rst,
    primary_ray_dispatch_if.slave   bus
);

    localparam logic [ID_W:0]   NUM_RAYS_W = (ID_W+1)'(NUM_RAYS);
    localparam logic [ID_W-1:0] LAST_ID    = ID_W'(NUM_RAYS - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [ID_W-1:0]        init_cnt_q, init_cnt_d;

    // Free list: circular FIFO. Depth is a power of two so head/tail wrap
    // naturally; count needs one extra bit to express "full".
    logic [ID_W-1:0]        head_q, head_d;
    logic [ID_W-1:0]        tail_q, tail_d;
    logic [ID_W:0]          count_q, count_d;
    logic [ID_W-1:0]        fl_mem_q [NUM_RAYS];

    // Slot table: pixelID per rayID, plus a busy bit per slot so that a
    // retire of an unallocated ID can be detected and dropped.
    logic [PIX_W-1:0]       slot_table_q [NUM_RAYS];
    logic [NUM_RAYS-1:0]    busy_q, busy_d;

    logic                   err_q, err_d;

    logic                   trav_valid_q, trav_valid_d;
    logic [ID_W+191:0]      trav_data_q, trav_data_d;

    logic                   pix_valid_q, pix_valid_d;
    logic [PIX_W-1:0]       pix_pixelID_q, pix_pixelID_d;
    logic [23:0]            pix_color_q, pix_color_d;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic                   run;
    logic                   fl_empty;
    logic                   prg_stall;
    logic                   done_stall;
    logic                   alloc_fire;
    logic                   retire_fire;
    logic                   retire_ok;
    logic                   retire_bad;
    logic                   fl_push;
    logic                   fl_pop;
    logic [ID_W-1:0]        fl_push_id;
    logic [ID_W-1:0]        pop_id;
    logic [PIX_W-1:0]       ray_pix;
    logic [191:0]           ray_geom;

    assign run        = (state_q == ST_RUN);
    assign fl_empty   = (count_q == '0);

    // A full trav register that traversal is refusing blocks new rays, so
    // no ID is popped while the output cannot advance.
    assign prg_stall  = !run || fl_empty || (trav_valid_q && bus.trav_stall);
    assign done_stall = !run || (pix_valid_q && bus.pix_stall);

    assign alloc_fire  = bus.prg_to_shader_valid && !prg_stall;
    assign retire_fire = bus.done_valid && !done_stall;

    // Retires of non-busy IDs are consumed but otherwise ignored.
    assign retire_ok   = retire_fire &&  busy_q[bus.done_rayID];
    assign retire_bad  = retire_fire && !busy_q[bus.done_rayID];

    // During INIT the list is seeded with 0..NUM_RAYS-1; afterwards the
    // only pushes are retired IDs.
    assign fl_push     = !run || retire_ok;
    assign fl_push_id  = run ? bus.done_rayID : init_cnt_q;
    assign fl_pop      = alloc_fire;
    assign pop_id      = fl_mem_q[head_q];

    assign ray_pix     = bus.prg_to_shader_data[PIX_W+191:192];
    assign ray_geom    = bus.prg_to_shader_data[191:0];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        busy_d        = busy_q;
        err_d         = err_q;
        trav_valid_d  = trav_valid_q;
        trav_data_d   = trav_data_q;
        pix_valid_d   = pix_valid_q;
        pix_pixelID_d = pix_pixelID_q;
        pix_color_d   = pix_color_q;

        // INIT seeds one free-list entry per cycle, then RUN forever.
        if (!run) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_ID) begin
                state_d = ST_RUN;
            end
        end

        // Free-list pointers; simultaneous push and pop keeps count.
        if (fl_push) begin
            tail_d = tail_q + 1'b1;
        end
        if (fl_pop) begin
            head_d = head_q + 1'b1;
        end
        case ({fl_push, fl_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // The popped ID comes from the free list and the retired ID is busy,
        // so these two indices never collide within one cycle.
        if (alloc_fire) begin
            busy_d[pop_id] = 1'b1;
        end
        if (retire_ok) begin
            busy_d[bus.done_rayID] = 1'b0;
        end

        if (retire_bad) begin
            err_d = 1'b1;
        end

        // Traversal output register: load on transfer, hold under stall,
        // clear once accepted with nothing new behind it.
        if (alloc_fire) begin
            trav_valid_d = 1'b1;
            trav_data_d  = {pop_id, ray_geom};
        end else if (trav_valid_q && !bus.trav_stall) begin
            trav_valid_d = 1'b0;
            trav_data_d  = '0;
        end

        // Pixel output register: same pattern; data is left in place after
        // acceptance, only valid drops.
        if (retire_ok) begin
            pix_valid_d   = 1'b1;
            pix_pixelID_d = slot_table_q[bus.done_rayID];
            pix_color_d   = bus.done_color;
        end else if (pix_valid_q && !bus.pix_stall) begin
            pix_valid_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_INIT;
            init_cnt_q    <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            busy_q        <= '0;
            err_q         <= 1'b0;
            trav_valid_q  <= 1'b0;
            trav_data_q   <= '0;
            pix_valid_q   <= 1'b0;
            pix_pixelID_q <= '0;
            pix_color_q   <= '0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            trav_valid_q  <= trav_valid_d;
            trav_data_q   <= trav_data_d;
            pix_valid_q   <= pix_valid_d;
            pix_pixelID_q <= pix_pixelID_d;
            pix_color_q   <= pix_color_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage arrays (no reset needed: contents are only read for entries
    // that were written since the last reset, guarded by count/busy).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (fl_push) begin
            fl_mem_q[tail_q] <= fl_push_id;
        end
        if (alloc_fire) begin
            slot_table_q[pop_id] <= ray_pix;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.prg_to_shader_stall = prg_stall;
    assign bus.done_stall          = done_stall;
    assign bus.trav_valid          = trav_valid_q;
    assign bus.trav_data           = trav_data_q;
    assign bus.pix_valid           = pix_valid_q;
    assign bus.pix_pixelID         = pix_pixelID_q;
    assign bus.pix_color           = pix_color_q;
    assign bus.err                 = err_q;
    // During INIT count climbs from 0, so the slot count is forced to 0.
    assign bus.in_flight           = run ? (NUM_RAYS_W - count_q) : '0;

endmodule
`default_nettype wire

// File: doc/primary_ray_dispatch.md
Name: primary_ray_dispatch

Overview:
Sits directly downstream of the primary ray generator and consumes its ray stream over the valid/stall handshake. Each accepted ray gets a rayID from a free list of NUM_RAYS slots. The block records the ray's pixelID in a slot table and forwards origin, dir and rayID to traversal. When the shader retires a rayID with its final colour, the block looks up the pixelID, emits a pixel write, and returns the rayID to the free list.

Parameters:
NUM_RAYS, 16, number of ray slots in flight; power of two, 2..64.
ID_W, 4, rayID width; equals clog2(NUM_RAYS).
PIX_W, 19, pixelID width (640x480 frame).

Ports:
clk  in  1  clock
rst  in  1  reset
prg_to_shader_valid  in  1  upstream ray valid
prg_to_shader_data  in  PIX_W+192  {pixelID, origin.xyz, dir.xyz}; floats are 32 b each, x in MSBs
prg_to_shader_stall  out  1  backpressure to upstream
trav_valid  out  1  ray valid to traversal
trav_data  out  ID_W+192  {rayID, origin.xyz, dir.xyz}
trav_stall  in  1  traversal backpressure
done_valid  in  1  shader retire valid
done_rayID  in  ID_W  retired rayID
done_color  in  24  RGB888 colour
done_stall  out  1  backpressure to shader
pix_valid  out  1  pixel write valid
pix_pixelID  out  PIX_W  pixel address
pix_color  out  24  pixel colour
pix_stall  in  1  frame-buffer backpressure
in_flight  out  ID_W+1  allocated slot count
err  out  1  sticky protocol error

Behaviour:
- Reset: rst asynchronous, active-high; clock clk. On reset: state=INIT, free-list head/tail/count=0, init counter=0, in_flight=0, err=0, trav_valid=0, pix_valid=0, trav_data=0, pix_pixelID=0, pix_color=0. prg_to_shader_stall=1 and done_stall=1 while in reset.
- INIT state:
  - Pushes IDs 0,1,...,NUM_RAYS-1 into the free list, one per cycle.
  - Goes to RUN after NUM_RAYS cycles, then stays in RUN until reset.
  - prg_to_shader_stall=1 and done_stall=1 throughout INIT.
- Free list: circular FIFO of depth NUM_RAYS. Pops are in FIFO order, so the first rays after reset get IDs 0,1,2,... in order. A same-cycle push and pop leaves count unchanged. An empty list blocks allocation; a push to a full list cannot occur legally.
- Allocate path:
  - Transfer fires when prg_to_shader_valid && ~prg_to_shader_stall.
  - prg_to_shader_stall = (state!=RUN) || freelist_empty || (trav_valid && trav_stall).
  - On transfer: pop ID, write slot_table[ID]=pixelID, set slot_busy[ID]=1, and load the trav output register. trav_valid=1 on the next cycle (latency 1).
  - trav register holds its value while trav_valid && trav_stall. It clears when accepted with no new transfer.
  - Back-to-back transfers give 1 ray per cycle.
- Retire path:
  - Accept fires when done_valid && ~done_stall.
  - done_stall = (state!=RUN) || (pix_valid && pix_stall).
  - On accept: read slot_table[done_rayID] into pix_pixelID, latch done_color into pix_color, set pix_valid=1 next cycle (latency 1).
  - In the same cycle: push done_rayID to the free list and clear slot_busy.
  - Pixel output holds under pix_stall.
- Simultaneous allocate and retire in one cycle:
  - Both proceed.
  - in_flight is unchanged.
  - A popped ID is never the ID pushed that cycle.
  - A table write and a read of different IDs is legal.
- Retire of a non-busy ID: set err=1 (sticky until reset), drop the retire (no push, no pix output), and still consume it (done_stall unaffected).
- in_flight = NUM_RAYS - freelist_count in RUN; 0 in INIT. Never exceeds NUM_RAYS.
- Reset mid-operation: all in-flight rays are lost, outputs return to reset values, and INIT reruns.

Test Plan:
- Reset, hold prg_to_shader_valid=1 -> stall=1 for exactly 16 cycles after rst falls. First trav_valid appears 1 cycle after the first transfer with rayID=0, then rayIDs 1,2,3 on consecutive cycles.
- Send 17 rays with no retires -> rays get IDs 0..15, in_flight=16. prg_to_shader_stall=1 holding the 17th ray. Retire ID 5 with colour 0xFF0000 -> pix_valid with the pixelID sent as ray 6 and colour 0xFF0000. The 17th ray is accepted the next cycle with rayID=5.
- trav_stall=1 for 4 cycles with the trav register full -> trav_data stable, prg_to_shader_stall=1, no IDs popped. Release -> rays resume at 1/cycle, no loss or duplication.
- With in_flight=8, allocate and retire ID 3 in the same cycle -> in_flight stays 8, pix_valid next cycle, new rayID is not 3.
- pix_stall=1 while pix_valid -> done_stall=1, pix outputs stable. Then retire ID 9 with slot 9 free -> err=1 and stays 1, no pix output, free-list count unchanged.
- Assert rst with 10 rays in flight and trav_valid=1 -> trav_valid=0, pix_valid=0, in_flight=0, err=0 immediately. INIT reruns, then first rayID=0.
